// File: rtl/nes_bus_pkg.sv
// Shared types and default constants for the CPU bus controller and its
// sprite DMA engine.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    localparam logic [15:0] DEF_DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;
    localparam logic [15:0] DEF_PPU_MATCH     = 16'h2000;
    localparam logic [15:0] DEF_PPU_MASK      = 16'hE000;

    // Index width for a power-of-two transfer length (at least one bit).
    function automatic int clog2_len(input int len);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < len) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nes_cpu_bus_dma_if.sv
// CPU-side bus bundle: CPU request, memory/PPU read returns and shared bus.
// Handshake: the CPU may only complete a read cycle when cpu_rdy is high;
// cpu_rdy is cpu_rdy_in gated off while the DMA engine owns the bus. A
// 6502 write cycle ignores cpu_rdy, so writes always pass through.
interface nes_cpu_bus_dma_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_we;
    logic              cpu_rdy_in;
    logic              cpu_rdy;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] ppu_din;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_we;
    logic              ppu_sel_q;
    logic              dma_active;
    logic              dma_done;

    modport master (
        output cpu_addr, cpu_dout, cpu_we, cpu_rdy_in, mem_din, ppu_din,
        input  cpu_rdy, cpu_din, bus_addr, bus_dout, bus_we, ppu_sel_q,
               dma_active, dma_done
    );

    modport slave (
        input  cpu_addr, cpu_dout, cpu_we, cpu_rdy_in, mem_din, ppu_din,
        output cpu_rdy, cpu_din, bus_addr, bus_dout, bus_we, ppu_sel_q,
               dma_active, dma_done
    );
endinterface

// File: rtl/nes_oam_dma_fsm.sv
// Sprite DMA sequencer: holds state, byte index, source page and the
// free-running cycle parity used for odd-cycle alignment.
module nes_oam_dma_fsm
    import nes_bus_pkg::*;
#(
    parameter int                ADDR_W        = 16,
    parameter int                DATA_W        = 8,
    parameter int                DMA_LEN       = 256,
    parameter logic [ADDR_W-1:0] DMA_TRIG_ADDR = ADDR_W'(DEF_DMA_TRIG_ADDR),
    parameter bit                ALIGN_ODD     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_dout_i,
    input  logic              cpu_we_i,
    output dma_state_t        state_o,
    output logic [ADDR_W-1:0] dma_addr_o,
    output logic              dma_active_o,
    output logic              dma_done_o
);
    localparam int               IDX_W    = clog2_len(DMA_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LEN - 1);

    dma_state_t        state_q;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] page_q;
    logic              parity_q;
    logic              dma_active_q;
    logic              dma_done_q;
    logic [7:0]        idx_byte;

    // Source page is the high byte; the index always lands in the low byte.
    assign idx_byte     = 8'(index_q);
    assign dma_addr_o   = ADDR_W'({page_q, idx_byte});
    assign state_o      = state_q;
    assign dma_active_o = dma_active_q;
    assign dma_done_o   = dma_done_q;

    // Sequencer: trigger capture, write-wait, optional alignment, copy loop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            index_q      <= '0;
            page_q       <= '0;
            parity_q     <= 1'b0;
            dma_active_q <= 1'b0;
            dma_done_q   <= 1'b0;
        end else begin
            parity_q   <= ~parity_q;
            dma_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_we_i && (cpu_addr_i == DMA_TRIG_ADDR)) begin
                        page_q       <= cpu_dout_i;
                        state_q      <= HALT;
                        dma_active_q <= 1'b1;
                    end
                end
                HALT: begin
                    // The 6502 keeps writing through RDY; wait for a read cycle.
                    if (!cpu_we_i) begin
                        state_q <= (ALIGN_ODD && parity_q) ? ALIGN : READ;
                    end
                end
                ALIGN: state_q <= READ;
                READ:  state_q <= WRITE;
                WRITE: begin
                    if (index_q == IDX_LAST) begin
                        index_q      <= '0;
                        state_q      <= DONE;
                        dma_active_q <= 1'b0;
                        dma_done_q   <= 1'b1;
                    end else begin
                        index_q <= index_q + IDX_W'(1);
                        state_q <= READ;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/nes_cpu_bus_dma.sv
// CPU bus controller: registered PPU decode, CPU read-data mux, and the
// shared-bus mux between CPU pass-through and the sprite DMA engine.
module nes_cpu_bus_dma
    import nes_bus_pkg::*;
#(
    parameter int                ADDR_W        = 16,
    parameter int                DATA_W        = 8,
    parameter int                DMA_LEN       = 256,
    parameter logic [ADDR_W-1:0] DMA_TRIG_ADDR = ADDR_W'(DEF_DMA_TRIG_ADDR),
    parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = ADDR_W'(DEF_OAM_DATA_ADDR),
    parameter logic [ADDR_W-1:0] PPU_MATCH     = ADDR_W'(DEF_PPU_MATCH),
    parameter logic [ADDR_W-1:0] PPU_MASK      = ADDR_W'(DEF_PPU_MASK),
    parameter bit                ALIGN_ODD     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    nes_cpu_bus_dma_if.slave bif,
    output dma_state_t       dbg_state_o
);
    dma_state_t        state;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_active;
    logic              dma_done;
    logic              ppu_sel_q;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_we;

    nes_oam_dma_fsm #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .DMA_LEN       (DMA_LEN),
        .DMA_TRIG_ADDR (DMA_TRIG_ADDR),
        .ALIGN_ODD     (ALIGN_ODD)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr_i   (bif.cpu_addr),
        .cpu_dout_i   (bif.cpu_dout),
        .cpu_we_i     (bif.cpu_we),
        .state_o      (state),
        .dma_addr_o   (dma_addr),
        .dma_active_o (dma_active),
        .dma_done_o   (dma_done)
    );

    // PPU decode registered so it lines up with the 1-cycle memory read.
    always_ff @(posedge clk) begin
        if (reset) begin
            ppu_sel_q <= 1'b0;
        end else begin
            ppu_sel_q <= ((bif.cpu_addr & PPU_MASK) == PPU_MATCH) ||
                         (bif.cpu_addr == DMA_TRIG_ADDR);
        end
    end

    // Shared bus: CPU pass-through unless the DMA engine is driving a cycle.
    always_comb begin
        bus_addr = bif.cpu_addr;
        bus_dout = bif.cpu_dout;
        bus_we   = bif.cpu_we;
        case (state)
            ALIGN: bus_we = 1'b0;
            READ: begin
                bus_addr = dma_addr;
                bus_we   = 1'b0;
            end
            WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_dout = bif.mem_din;
                bus_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bif.bus_addr   = bus_addr;
    assign bif.bus_dout   = bus_dout;
    assign bif.bus_we     = bus_we;
    assign bif.ppu_sel_q  = ppu_sel_q;
    assign bif.cpu_din    = ppu_sel_q ? bif.ppu_din : bif.mem_din;
    assign bif.cpu_rdy    = bif.cpu_rdy_in & ~dma_active;
    assign bif.dma_active = dma_active;
    assign bif.dma_done   = dma_done;
    assign dbg_state_o    = state;
endmodule

// File: tb/tb_nes_cpu_bus_dma.sv
// Bench for nes_cpu_bus_dma: decode vectors, full/aligned/write-held DMA,
// reset mid-transfer and a DMA_LEN=16 instance.
`timescale 1ns/1ps
module tb_nes_cpu_bus_dma;
  import nes_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nes_cpu_bus_dma_if bif();
  nes_cpu_bus_dma_if bif16();
  dma_state_t dbg_state;
  dma_state_t dbg_state16;

  nes_cpu_bus_dma dut (
    .clk         (clk),
    .reset       (reset),
    .bif         (bif),
    .dbg_state_o (dbg_state)
  );

  nes_cpu_bus_dma #(.DMA_LEN(16)) dut16 (
    .clk         (clk),
    .reset       (reset),
    .bif         (bif16),
    .dbg_state_o (dbg_state16)
  );

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- environment models ----------------
  int   cyc = 0;
  logic tb_par;
  logic mem_ovr_en;
  logic [7:0] mem_ovr;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tb_par <= reset ? 1'b0 : ~tb_par;
  end

  // Synchronous memory: byte at address A reads as A[7:0]^5A.
  always @(posedge clk) begin
    bif.mem_din   <= mem_ovr_en ? mem_ovr : (bif.bus_addr[7:0] ^ 8'h5A);
    bif16.mem_din <= bif16.bus_addr[7:0] ^ 8'h5A;
  end

  // ---------------- scoreboards ----------------
  logic [24:0] exp_q[$];
  logic [24:0] exp16_q[$];
  logic [24:0] act_m;
  logic [24:0] act16_m;
  int rdy_low, done_cnt, wr_cnt, first_rd, trig_cyc;
  int rdy16_low, done16_cnt;

  task automatic push_dma(input logic [7:0] page, input int len, input bit to16);
    for (int i = 0; i < len; i++) begin
      if (to16) begin
        exp16_q.push_back({1'b0, page, 8'(i), 8'h00});
        exp16_q.push_back({1'b1, 16'h2004, 8'(i) ^ 8'h5A});
      end else begin
        exp_q.push_back({1'b0, page, 8'(i), 8'h00});
        exp_q.push_back({1'b1, 16'h2004, 8'(i) ^ 8'h5A});
      end
    end
  endtask

  // DMA bus cycles are those where the engine drives an address other than the CPU's.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.dma_active && (bif.bus_addr != bif.cpu_addr)) begin
        act_m = {bif.bus_we, bif.bus_addr, bif.bus_we ? bif.bus_dout : 8'h00};
        if (!bif.bus_we && first_rd < 0) first_rd = cyc;
        if (bif.bus_we) wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dma_extra: got %0h expected no bus cycle", act_m);
        end else begin
          check("dma_bus", 32'(act_m), 32'(exp_q.pop_front()));
        end
      end
      if (!bif.cpu_rdy) rdy_low++;
      if (bif.dma_done) done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bif16.dma_active && (bif16.bus_addr != bif16.cpu_addr)) begin
        act16_m = {bif16.bus_we, bif16.bus_addr, bif16.bus_we ? bif16.bus_dout : 8'h00};
        if (exp16_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dma16_extra: got %0h expected no bus cycle", act16_m);
        end else begin
          check("dma16_bus", 32'(act16_m), 32'(exp16_q.pop_front()));
        end
      end
      if (!bif16.cpu_rdy) rdy16_low++;
      if (bif16.dma_done) done16_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // want_align=0 picks a trigger cycle whose HALT cycle sees parity 0.
  task automatic run_trigger(input logic [7:0] page, input bit want_align);
    while (tb_par != (want_align ? 1'b0 : 1'b1)) begin
      @(posedge clk); #1;
    end
    rdy_low = 0; done_cnt = 0; wr_cnt = 0; first_rd = -1;
    trig_cyc = cyc;
    bif.cpu_addr = 16'h4014; bif.cpu_dout = page; bif.cpu_we = 1'b1;
    @(posedge clk); #1;
    bif.cpu_we = 1'b0; bif.cpu_addr = 16'h8000; bif.cpu_dout = 8'h00;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dma_timeout: got no dma_done expected one within %0d cycles", budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_dma(input string tag, input int exp_rdy, input int exp_lat);
    check({tag, "_rdy_low"}, 32'(rdy_low), 32'(exp_rdy));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_read_latency"}, 32'(first_rd - trig_cyc), 32'(exp_lat));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- decode vectors ----------------
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic        rdy_in;
    logic [7:0]  ppu;
    logic [7:0]  mem;
    logic        exp_sel;
    logic [7:0]  exp_din;
    logic        exp_rdy;
  } dec_vec_t;

  dec_vec_t vecs[9];
  int wait_n;

  initial begin
    vecs[0] = '{16'h2002, 8'h00, 1'b0, 1'b1, 8'hA5, 8'h11, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{16'h0778, 8'h00, 1'b0, 1'b1, 8'hA5, 8'h11, 1'b0, 8'h11, 1'b1};
    vecs[2] = '{16'h3FFF, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h11, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{16'h4014, 8'h00, 1'b0, 1'b1, 8'h77, 8'h11, 1'b1, 8'h77, 1'b1};
    vecs[4] = '{16'h1FFF, 8'h42, 1'b1, 1'b1, 8'h99, 8'h66, 1'b0, 8'h66, 1'b1};
    vecs[5] = '{16'h4000, 8'h00, 1'b0, 1'b0, 8'h99, 8'h24, 1'b0, 8'h24, 1'b0};
    vecs[6] = '{16'h2000, 8'h5A, 1'b1, 1'b1, 8'hC8, 8'h24, 1'b1, 8'hC8, 1'b1};
    vecs[7] = '{16'h6004, 8'h00, 1'b0, 1'b1, 8'hC8, 8'h81, 1'b0, 8'h81, 1'b1};
    vecs[8] = '{16'h4015, 8'h00, 1'b0, 1'b1, 8'h33, 8'h18, 1'b0, 8'h18, 1'b1};

    reset = 1'b1;
    mem_ovr_en = 1'b0; mem_ovr = 8'h00;
    bif.cpu_addr = 16'h2002; bif.cpu_dout = 8'h00; bif.cpu_we = 1'b0;
    bif.cpu_rdy_in = 1'b1; bif.ppu_din = 8'h00;
    bif16.cpu_addr = 16'h0000; bif16.cpu_dout = 8'h00; bif16.cpu_we = 1'b0;
    bif16.cpu_rdy_in = 1'b1; bif16.ppu_din = 8'h00;
    rdy_low = 0; done_cnt = 0; wr_cnt = 0; first_rd = -1; trig_cyc = 0;
    rdy16_low = 0; done16_cnt = 0;

    // Reset state (PPU address driven, decode must still read 0).
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ppu_sel", 32'(bif.ppu_sel_q), 32'd0);
    check("rst_dma_active", 32'(bif.dma_active), 32'd0);
    check("rst_dma_done", 32'(bif.dma_done), 32'd0);
    check("rst_cpu_rdy", 32'(bif.cpu_rdy), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Decode and pass-through table.
    mem_ovr_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      bif.cpu_addr = vecs[k].addr; bif.cpu_dout = vecs[k].dout; bif.cpu_we = vecs[k].we;
      bif.cpu_rdy_in = vecs[k].rdy_in; bif.ppu_din = vecs[k].ppu; mem_ovr = vecs[k].mem;
      @(negedge clk);
      check("dec_cpu_rdy", 32'(bif.cpu_rdy), 32'(vecs[k].exp_rdy));
      check("dec_bus_addr", 32'(bif.bus_addr), 32'(vecs[k].addr));
      check("dec_bus_we", 32'(bif.bus_we), 32'(vecs[k].we));
      check("dec_bus_dout", 32'(bif.bus_dout), 32'(vecs[k].dout));
      @(negedge clk);
      check("dec_ppu_sel", 32'(bif.ppu_sel_q), 32'(vecs[k].exp_sel));
      check("dec_cpu_din", 32'(bif.cpu_din), 32'(vecs[k].exp_din));
    end
    @(posedge clk); #1;
    mem_ovr_en = 1'b0; bif.cpu_we = 1'b0; bif.cpu_rdy_in = 1'b1; bif.cpu_addr = 16'h8000;

    // Full DMA, no alignment: 513 stalled cycles.
    push_dma(8'h02, 256, 1'b0);
    run_trigger(8'h02, 1'b0);
    wait_done(600);
    check_dma("even", 513, 2);

    // Full DMA with alignment cycle: 514 stalled cycles, READ one cycle later.
    push_dma(8'h02, 256, 1'b0);
    run_trigger(8'h02, 1'b1);
    wait_done(600);
    check_dma("odd", 514, 3);

    // Write-hold: two more CPU writes after the trigger, one of them a re-trigger.
    push_dma(8'h05, 256, 1'b0);
    while (tb_par != 1'b1) begin
      @(posedge clk); #1;
    end
    rdy_low = 0; done_cnt = 0; wr_cnt = 0; first_rd = -1;
    trig_cyc = cyc;
    bif.cpu_addr = 16'h4014; bif.cpu_dout = 8'h05; bif.cpu_we = 1'b1;
    @(posedge clk); #1;
    bif.cpu_dout = 8'h09;
    @(negedge clk);
    check("hold1_active", 32'(bif.dma_active), 32'd1);
    check("hold1_bus_we", 32'(bif.bus_we), 32'd1);
    check("hold1_bus_addr", 32'(bif.bus_addr), 32'h4014);
    check("hold1_bus_dout", 32'(bif.bus_dout), 32'h09);
    @(posedge clk); #1;
    bif.cpu_addr = 16'h4015; bif.cpu_dout = 8'hC3;
    @(negedge clk);
    check("hold2_bus_we", 32'(bif.bus_we), 32'd1);
    check("hold2_bus_addr", 32'(bif.bus_addr), 32'h4015);
    check("hold2_bus_dout", 32'(bif.bus_dout), 32'hC3);
    check("hold2_cpu_rdy", 32'(bif.cpu_rdy), 32'd0);
    @(posedge clk); #1;
    bif.cpu_we = 1'b0; bif.cpu_addr = 16'h8000; bif.cpu_dout = 8'h00;
    wait_done(700);
    check_dma("hold", 515, 4);

    // Reset at byte 100, with a trigger write in the reset cycle.
    push_dma(8'h02, 100, 1'b0);
    run_trigger(8'h02, 1'b0);
    wait_n = 0;
    while (wr_cnt < 100 && wait_n < 400) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("mid_bytes_written", 32'(wr_cnt), 32'd100);
    reset = 1'b1;
    bif.cpu_addr = 16'h4014; bif.cpu_dout = 8'h0B; bif.cpu_we = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bif.cpu_we = 1'b0; bif.cpu_addr = 16'h8000; bif.cpu_dout = 8'h00;
    @(negedge clk);
    check("mid_dma_active", 32'(bif.dma_active), 32'd0);
    check("mid_cpu_rdy", 32'(bif.cpu_rdy), 32'd1);
    check("mid_bus_addr", 32'(bif.bus_addr), 32'h8000);
    check("mid_bus_we", 32'(bif.bus_we), 32'd0);
    check("mid_state", 32'(dbg_state), 32'(IDLE));
    check("mid_queue_left", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_done", 32'(done_cnt), 32'd0);
    check("mid_still_idle", 32'(bif.dma_active), 32'd0);

    // Fresh transfer after the aborted one copies from page 03.
    push_dma(8'h03, 256, 1'b0);
    run_trigger(8'h03, 1'b0);
    wait_done(600);
    check_dma("after_rst", 513, 2);

    // DMA_LEN=16 instance, page 07: 33 stalled cycles.
    push_dma(8'h07, 16, 1'b1);
    while (tb_par != 1'b1) begin
      @(posedge clk); #1;
    end
    rdy16_low = 0; done16_cnt = 0;
    bif16.cpu_addr = 16'h4014; bif16.cpu_dout = 8'h07; bif16.cpu_we = 1'b1;
    @(posedge clk); #1;
    bif16.cpu_we = 1'b0; bif16.cpu_addr = 16'h8000; bif16.cpu_dout = 8'h00;
    wait_n = 0;
    while (done16_cnt == 0 && wait_n < 100) begin
      @(posedge clk); #1;
      wait_n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("len16_rdy_low", 32'(rdy16_low), 32'd33);
    check("len16_done_pulses", 32'(done16_cnt), 32'd1);
    check("len16_queue_left", 32'(exp16_q.size()), 32'd0);
    check("len16_state", 32'(dbg_state16), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
